seq_det_arb: RTL and testbench

SEQ_DET_ARB -- requirements
Module: seq_det_arb

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_prog.sv | 34 +++
 rtl/seq_det_arb.sv | 142 ++++++++++++++
 tb/tb_seq_det_arb.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector / round-robin arbiter slice.
package seq_det_pkg;

  localparam int unsigned DefN   = 4;
  localparam int unsigned DefWin = 16;
  localparam int unsigned PatW   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StReport
  } state_e;

endpackage

// File: rtl/seq_det_prog.sv
// Overlapping 4-bit pattern matcher; match is combinational on the bit being sampled.
module seq_det_prog
  import seq_det_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic            bit_in,
  input  logic [PatW-1:0] pat,
  output logic            match
);

  localparam logic [2:0] FillMax = 3'(PatW);

  logic [PatW-1:0] shift_q;
  logic [2:0]      fill_q;

  // Three bits already held plus the incoming one make a full pattern.
  assign match = en && (fill_q >= FillMax - 3'd1) && ({shift_q[PatW-2:0], bit_in} == pat);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else if (en) begin
      shift_q <= {shift_q[PatW-2:0], bit_in};
      if (fill_q != FillMax) begin
        fill_q <= fill_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/seq_det_arb.sv
// Round-robin grant of one shared pattern detector to N serial requesters, one window at a time.
module seq_det_arb
  import seq_det_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned WIN = DefWin,
  localparam int unsigned CW = $clog2(WIN + 1),
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    seq_in,
  input  logic [3:0]      cfg_pat,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   done_id,
  output logic [CW-1:0]   done_cnt,
  output logic            done_abort
);

  localparam logic [CW-1:0] CntMax  = {CW{1'b1}};
  localparam logic [CW-1:0] LastBit = CW'(WIN - 1);

  state_e          state_q;
  logic [N-1:0]    gnt_q;
  logic            busy_q, done_q, done_abort_q;
  logic [IW-1:0]   done_id_q, last_id_q, gnt_id_q;
  logic [CW-1:0]   done_cnt_q, bit_cnt_q, match_cnt_q;
  logic [3:0]      pat_q;

  logic [IW-1:0]   pick_id;
  logic            still_req, cur_bit, det_en, det_clr, match;
  logic [CW-1:0]   cnt_next;

  // Smallest offset from last_id wins, so scan offsets from largest to smallest.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    pick_id = '0;
    for (int unsigned i = N; i >= 1; i--) begin
      idx = (32'(last_id_q) + i) % N;
      if (req[idx]) begin
        pick_id = IW'(idx);
      end
    end
  end

  assign still_req = req[gnt_id_q];
  assign cur_bit   = seq_in[gnt_id_q];
  assign det_en    = (state_q == StRun) && still_req;
  assign det_clr   = (state_q != StRun);
  assign cnt_next  = (match && (match_cnt_q != CntMax)) ? match_cnt_q + CW'(1) : match_cnt_q;

  seq_det_prog u_prog (
    .clk    (clk),
    .rst    (rst),
    .clr    (det_clr),
    .en     (det_en),
    .bit_in (cur_bit),
    .pat    (pat_q),
    .match  (match)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      done_cnt_q   <= '0;
      done_abort_q <= 1'b0;
      last_id_q    <= IW'(N - 1);
      gnt_id_q     <= '0;
      bit_cnt_q    <= '0;
      match_cnt_q  <= '0;
      pat_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StRun;
            gnt_q       <= N'(1) << pick_id;
            gnt_id_q    <= pick_id;
            busy_q      <= 1'b1;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            pat_q       <= cfg_pat;
          end
        end
        StRun: begin
          if (!still_req) begin
            // Dropped request: this cycle's bit is discarded.
            state_q      <= StReport;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            done_id_q    <= gnt_id_q;
            done_cnt_q   <= match_cnt_q;
            done_abort_q <= 1'b1;
          end else begin
            bit_cnt_q   <= bit_cnt_q + CW'(1);
            match_cnt_q <= cnt_next;
            if (bit_cnt_q == LastBit) begin
              state_q      <= StReport;
              gnt_q        <= '0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              done_id_q    <= gnt_id_q;
              done_cnt_q   <= cnt_next;
              done_abort_q <= 1'b0;
            end
          end
        end
        StReport: begin
          state_q      <= StIdle;
          last_id_q    <= gnt_id_q;
          done_q       <= 1'b0;
          done_id_q    <= '0;
          done_cnt_q   <= '0;
          done_abort_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign done_cnt   = done_cnt_q;
  assign done_abort = done_abort_q;

endmodule

// File: tb/tb_seq_det_arb.sv
// Directed bench for seq_det_arb: table of single-requester windows plus hand-written corners.
module tb_seq_det_arb;

  localparam int N   = 4;
  localparam int WIN = 16;
  localparam int CW  = $clog2(WIN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, seq_in, gnt;
  logic [3:0]    cfg_pat;
  logic          busy, done, done_abort;
  logic [1:0]    done_id;
  logic [CW-1:0] done_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_det_arb #(.N(N), .WIN(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .seq_in     (seq_in),
    .cfg_pat    (cfg_pat),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .done_cnt   (done_cnt),
    .done_abort (done_abort)
  );

  typedef struct {
    int          r;
    logic [3:0]  pat;
    logic [3:0]  pat_mid;
    logic [15:0] stream;
    int          nbits;
    int          cnt;
    int          abort;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts from IDLE at a negedge; ends at the negedge of the IDLE cycle after REPORT.
  task automatic run_window(input int k, input vec_t v);
    logic [N-1:0] oh;
    int gerr;
    oh      = N'(1) << v.r;
    gerr    = 0;
    req     = oh;
    cfg_pat = v.pat;
    seq_in  = '0;
    @(negedge clk);
    chk($sformatf("v%0d busy_start", k), int'(busy), 1);
    chk($sformatf("v%0d gnt_start", k), int'(gnt), int'(oh));
    for (int i = 0; i < v.nbits; i++) begin
      if (gnt !== oh || busy !== 1'b1 || done !== 1'b0) gerr++;
      if (i == 2) cfg_pat = v.pat_mid;
      seq_in = v.stream[15-i] ? oh : ~oh;
      @(negedge clk);
    end
    chk($sformatf("v%0d gnt_run_errs", k), gerr, 0);
    if (v.nbits < WIN) begin
      req    = '0;
      seq_in = v.stream[15-v.nbits] ? oh : ~oh;
      @(negedge clk);
    end
    chk($sformatf("v%0d done", k), int'(done), 1);
    chk($sformatf("v%0d done_id", k), int'(done_id), v.r);
    chk($sformatf("v%0d done_cnt", k), int'(done_cnt), v.cnt);
    chk($sformatf("v%0d done_abort", k), int'(done_abort), v.abort);
    chk($sformatf("v%0d gnt_report", k), int'(gnt), 0);
    chk($sformatf("v%0d busy_report", k), int'(busy), 0);
    req    = '0;
    seq_in = '0;
    @(negedge clk);
    chk($sformatf("v%0d done_after", k), int'({done, done_abort, done_cnt, done_id}), 0);
  endtask

  initial begin
    int derr;
    logic [N-1:0] exp_g;

    vecs[0] = '{0, 4'b1101, 4'b1101, 16'b1101_1010_0000_0000, 16, 2, 0};
    vecs[1] = '{2, 4'b1101, 4'b1101, 16'b1101_0000_0000_0000, 5, 1, 1};
    vecs[2] = '{1, 4'b1111, 4'b1111, 16'hFFFF, 16, 13, 0};
    vecs[3] = '{0, 4'b1111, 4'b1111, 16'hE000, 16, 0, 0};
    vecs[4] = '{1, 4'b1010, 4'b1010, 16'hAAAA, 16, 7, 0};
    vecs[5] = '{2, 4'b0110, 4'b0110, 16'h6666, 12, 3, 1};
    vecs[6] = '{3, 4'b1101, 4'b1101, 16'hD000, 3, 0, 1};
    vecs[7] = '{3, 4'b0000, 4'b0000, 16'h0000, 0, 0, 1};
    vecs[8] = '{0, 4'b1101, 4'b0000, 16'hD000, 16, 1, 0};
    vecs[9] = '{1, 4'b0000, 4'b0000, 16'h0000, 16, 13, 0};

    rst     = 1'b0;
    req     = '0;
    seq_in  = '0;
    cfg_pat = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({gnt, busy, done, done_id, done_cnt, done_abort}), 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_no_req", int'({gnt, busy, done}), 0);

    for (int k = 0; k < 10; k++) begin
      run_window(k, vecs[k]);
    end

    // Reset after 8 bits of a window: no report, reset values next cycle.
    req     = 4'b0010;
    cfg_pat = 4'b1111;
    seq_in  = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("midrst_busy_before", int'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", int'({gnt, busy, done, done_id, done_cnt, done_abort}), 0);
    rst    = 1'b1;
    req    = '0;
    seq_in = '0;
    derr   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) derr++;
    end
    chk("midrst_no_done", derr, 0);

    // All requesting after reset: grant order 0,1,2,3,0 with REPORT+IDLE gaps.
    req = 4'b1111;
    for (int k = 0; k < 5 * 18; k++) begin
      int w, pos;
      @(negedge clk);
      w     = k / 18;
      pos   = k % 18;
      exp_g = (pos < 16) ? (N'(1) << (w % 4)) : '0;
      chk($sformatf("rr_gnt_c%0d", k), int'(gnt), int'(exp_g));
      if (pos == 16) begin
        chk($sformatf("rr_done_id_w%0d", w), int'({done, done_id}), int'({1'b1, 2'(w % 4)}));
      end else begin
        chk($sformatf("rr_nodone_c%0d", k), int'(done), 0);
      end
    end
    req = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
